writeback_align_unit: RTL

//  Parametrised writeback stage: aligns/extends load data, merges two-beat misaligned loads, registers

---
 rtl/wb_pkg.sv | 14 +
 rtl/writeback_align_unit_load_align.sv | 37 +++
 rtl/writeback_align_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load size codes and the
// split-load tracking state machine encoding.
package wb_pkg;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_PEND = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_align_unit_load_align.sv
// Combinational load aligner: picks a DATA_W slice out of a two-word window
// at a byte offset, then masks it to the load size and sign/zero extends.
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]              hi_word_i,
    input  logic [DATA_W-1:0]              lo_word_i,
    input  logic [$clog2(DATA_W/8)-1:0]    off_i,
    input  logic [1:0]                     size_i,
    input  logic                           sgn_i,
    output logic [DATA_W-1:0]              data_o
);

    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int SH_W  = OFF_W + 4;

    logic [2*DATA_W-1:0] window;
    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   slice;

    assign window = {hi_word_i, lo_word_i};
    assign shamt  = {1'b0, off_i, 3'b000};
    assign slice  = window[shamt +: DATA_W];

    // Reduce the shifted slice to the requested size; reserved size acts as a full word
    always_comb begin
        data_o = slice;
        case (size_i)
            LD_BYTE: data_o = {{(DATA_W-8){sgn_i & slice[7]}}, slice[7:0]};
            LD_HALF: data_o = {{(DATA_W-16){sgn_i & slice[15]}}, slice[15:0]};
            default: data_o = slice;
        endcase
    end

endmodule

// File: rtl/writeback_align_unit.sv
// Writeback stage: aligns and extends load data, stitches two-beat misaligned
// loads together, and registers the register-file write ports.
// Optional build macro WB_RETIRE_CNT_EN adds a retired-beat counter output.
module writeback_align_unit
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NPORTS = 2,
    parameter int TGT_W  = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic                          halt,
    input  logic                          valid_in,
    input  logic [NPORTS-1:0]             wr_req,
    input  logic [NPORTS*TGT_W-1:0]       tgt_in,
    input  logic [NPORTS*DATA_W-1:0]      alu_in,
    input  logic                          is_load,
    input  logic [1:0]                    ld_size,
    input  logic                          ld_signed,
    input  logic                          ld_split,
    input  logic [$clog2(DATA_W/8)-1:0]   addr_lo,
    input  logic [DATA_W-1:0]             mem_data,
    output logic [NPORTS*DATA_W-1:0]      result_out,
    output logic [NPORTS-1:0]             wb_we,
    output logic [NPORTS*TGT_W-1:0]       wb_tgt,
    output logic [NPORTS*DATA_W-1:0]      wb_data,
    output logic                          split_pending
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]                   retire_cnt
`endif
);

    localparam int OFF_W = $clog2(DATA_W/8);

    logic                       advance;
    logic                       lowSplit;
    logic                       inPend;

    wb_state_e                  state_q, state_d;
    logic [DATA_W-1:0]          bufData_q, bufData_d;
    logic [OFF_W-1:0]           bufOff_q, bufOff_d;
    logic [1:0]                 bufSize_q, bufSize_d;
    logic                       bufSigned_q, bufSigned_d;

    logic [NPORTS-1:0]          wbWe_q, wbWe_d;
    logic [NPORTS*TGT_W-1:0]    wbTgt_q;
    logic [NPORTS*DATA_W-1:0]   wbData_q;

    logic [DATA_W-1:0]          alignHi, alignLo, loadData;
    logic [OFF_W-1:0]           alignOff;
    logic [1:0]                 alignSize;
    logic                       alignSigned;

    assign advance  = clk_en & ~halt;
    assign lowSplit = valid_in & is_load & ld_split;
    assign inPend   = (state_q == WB_PEND);

    // While a split is pending the buffered low beat forms the bottom of the window
    always_comb begin
        alignHi     = inPend ? mem_data     : '0;
        alignLo     = inPend ? bufData_q    : mem_data;
        alignOff    = inPend ? bufOff_q     : addr_lo;
        alignSize   = inPend ? bufSize_q    : ld_size;
        alignSigned = inPend ? bufSigned_q  : ld_signed;
    end

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .hi_word_i (alignHi),
        .lo_word_i (alignLo),
        .off_i     (alignOff),
        .size_i    (alignSize),
        .sgn_i     (alignSigned),
        .data_o    (loadData)
    );

    // Forwarding results: port 0 may come from memory, the rest always from the ALU
    always_comb begin
        result_out = alu_in;
        if (is_load) begin
            result_out[DATA_W-1:0] = loadData;
        end
    end

    // Split tracking: a low beat captures the buffer, any other valid beat closes the split
    always_comb begin
        state_d     = state_q;
        bufData_d   = bufData_q;
        bufOff_d    = bufOff_q;
        bufSize_d   = bufSize_q;
        bufSigned_d = bufSigned_q;
        if (valid_in) begin
            if (lowSplit) begin
                state_d     = WB_PEND;
                bufData_d   = mem_data;
                bufOff_d    = addr_lo;
                bufSize_d   = ld_size;
                bufSigned_d = ld_signed;
            end else if (state_q == WB_PEND) begin
                state_d = WB_IDLE;
            end
        end
    end

    // Write enables: skip r0, skip the low split beat on port 0, lowest port wins a target clash
    always_comb begin
        wbWe_d = '0;
        for (int i = 0; i < NPORTS; i++) begin
            wbWe_d[i] = valid_in & wr_req[i] & (tgt_in[i*TGT_W +: TGT_W] != '0);
            if (i == 0 && lowSplit) begin
                wbWe_d[i] = 1'b0;
            end
            for (int j = 0; j < i; j++) begin
                if (wbWe_d[j] && (tgt_in[j*TGT_W +: TGT_W] == tgt_in[i*TGT_W +: TGT_W])) begin
                    wbWe_d[i] = 1'b0;
                end
            end
        end
    end

    // Stage registers only move when the pipeline advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WB_IDLE;
            bufData_q   <= '0;
            bufOff_q    <= '0;
            bufSize_q   <= '0;
            bufSigned_q <= 1'b0;
            wbWe_q      <= '0;
            wbTgt_q     <= '0;
            wbData_q    <= '0;
        end else if (advance) begin
            state_q     <= state_d;
            bufData_q   <= bufData_d;
            bufOff_q    <= bufOff_d;
            bufSize_q   <= bufSize_d;
            bufSigned_q <= bufSigned_d;
            wbWe_q      <= wbWe_d;
            wbTgt_q     <= tgt_in;
            wbData_q    <= result_out;
        end
    end

    assign wb_we         = wbWe_q;
    assign wb_tgt        = wbTgt_q;
    assign wb_data       = wbData_q;
    assign split_pending = inPend;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCnt_q;

    // Count every advancing beat that completes an instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retireCnt_q <= '0;
        end else if (advance && valid_in && !lowSplit) begin
            retireCnt_q <= retireCnt_q + 32'd1;
        end
    end

    assign retire_cnt = retireCnt_q;
`endif

endmodule
